// File: rtl/common_pkg.sv
// common_pkg: shared types for the run controller.
//   run_state_t - run controller state, also exported on the 'state' port.
package common_pkg;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    FLUSH  = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5
  } run_state_t;

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// sat_counter: W-bit up-counter with synchronous clear that sticks at all-ones.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   clr       - clear to 0 (wins over inc)
//   inc       - increment by one unless already all-ones
//   count     - registered count value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: sequences the five-stage core through program load,
// flush, free-run / single-step execution, drain and halt.
//   clk, rst            - clock, synchronous active-high reset
//   load_valid          - loader wrote an instruction word (aborts any run)
//   load_done           - program load complete pulse
//   step_mode, step_req - single-step select level and advance pulse
//   halt_req            - graceful stop request
//   retire_valid/_ebreak- WB retirement, and whether it is ebreak/ecall
//   core_rst, core_run, fetch_en, halted - registered pipeline controls/status
//   state               - current run_state_t
//   cycle_count, retire_count - saturating perf counters, cleared on flush
module pipeline_run_controller
  import common_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 5,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             load_done,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             retire_valid,
  input  logic             retire_ebreak,
  output logic             core_rst,
  output logic             core_run,
  output logic             fetch_en,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int unsigned CMAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int unsigned DW   = $clog2(CMAX + 1);

  run_state_t    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          core_rst_q, core_rst_d;
  logic          core_run_q, core_run_d;
  logic          fetch_en_q, fetch_en_d;
  logic          halted_q, halted_d;
  logic          perf_clr;
  logic          ebreak_hit;

  // Only an ebreak retiring in an advancing cycle is real; otherwise WB is stale.
  assign ebreak_hit = retire_valid & retire_ebreak & core_run_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    perf_clr = 1'b0;
    if (load_valid) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD, HALTED: begin
          if (load_done) begin
            state_d  = FLUSH;
            cnt_d    = DW'(FLUSH_CYCLES - 1);
            perf_clr = 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_d = step_mode ? STEP : RUN;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        RUN, STEP: begin
          if (ebreak_hit) begin
            state_d = HALTED;
          end else if (halt_req) begin
            state_d = DRAIN;
            cnt_d   = DW'(DRAIN_CYCLES - 1);
          end else if ((state_q == RUN) && step_mode) begin
            state_d = STEP;
          end else if ((state_q == STEP) && !step_mode) begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          if (ebreak_hit || (cnt_q == '0)) begin
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        default: state_d = LOAD;
      endcase
    end

    // Outputs are decoded from the next state so they are registered with it.
    // A step pulse is granted only when staying in STEP and no pulse is live.
    core_rst_d = (state_d == LOAD) || (state_d == FLUSH);
    core_run_d = (state_d == RUN) || (state_d == DRAIN) ||
                 ((state_d == STEP) && (state_q == STEP) && step_req && !core_run_q);
    fetch_en_d = (state_d == RUN) || (state_d == STEP);
    halted_d   = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      core_run_q <= 1'b0;
      fetch_en_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
      core_run_q <= core_run_d;
      fetch_en_q <= fetch_en_d;
      halted_q   <= halted_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (core_run_q),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (core_run_q & retire_valid),
    .count (retire_count)
  );

  assign core_rst = core_rst_q;
  assign core_run = core_run_q;
  assign fetch_en = fetch_en_q;
  assign halted   = halted_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Testbench for pipeline_run_controller: directed scenarios plus random
// stimulus, checked every cycle against a rule-level model, with two DUTs
// (32-bit and 4-bit counters) sharing the same inputs.
module tb_pipeline_run_controller;

  localparam int FL = 5;
  localparam int DR = 4;

  logic clk = 1'b0;
  logic rst, load_valid, load_done, step_mode, step_req, halt_req, retire_valid, retire_ebreak;

  logic        core_rst, core_run, fetch_en, halted;
  logic [2:0]  state;
  logic [31:0] cycle_count, retire_count;

  logic        core_rst4, core_run4, fetch_en4, halted4;
  logic [2:0]  state4;
  logic [3:0]  cycle_count4, retire_count4;

  always #5 clk = ~clk;

  pipeline_run_controller #(.FLUSH_CYCLES(FL), .DRAIN_CYCLES(DR), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_done(load_done),
    .step_mode(step_mode), .step_req(step_req), .halt_req(halt_req),
    .retire_valid(retire_valid), .retire_ebreak(retire_ebreak),
    .core_rst(core_rst), .core_run(core_run), .fetch_en(fetch_en), .halted(halted),
    .state(state), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  pipeline_run_controller #(.FLUSH_CYCLES(FL), .DRAIN_CYCLES(DR), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_done(load_done),
    .step_mode(step_mode), .step_req(step_req), .halt_req(halt_req),
    .retire_valid(retire_valid), .retire_ebreak(retire_ebreak),
    .core_rst(core_rst4), .core_run(core_run4), .fetch_en(fetch_en4), .halted(halted4),
    .state(state4), .cycle_count(cycle_count4), .retire_count(retire_count4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state numbered as in the spec (0 LOAD .. 5 HALTED), run flag,
  // shared countdown and unbounded perf counts.
  int     m_state = 0;
  bit     m_run   = 1'b0;
  int     m_cnt   = 0;
  longint m_cyc   = 0;
  longint m_ret   = 0;
  int     ns;
  bit     nrun, ebk;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_run = 1'b0; m_cnt = 0; m_cyc = 0; m_ret = 0;
    end else begin
      ebk = retire_valid && retire_ebreak && m_run;
      if (m_run) m_cyc++;
      if (m_run && retire_valid) m_ret++;
      ns = m_state;
      if (load_valid) ns = 0;
      else if ((m_state == 0 || m_state == 5) && load_done) begin
        ns = 1; m_cnt = FL - 1; m_cyc = 0; m_ret = 0;
      end
      else if (m_state == 1) begin
        if (m_cnt == 0) ns = step_mode ? 3 : 2; else m_cnt--;
      end
      else if ((m_state >= 2 && m_state <= 4) && ebk) ns = 5;
      else if ((m_state == 2 || m_state == 3) && halt_req) begin
        ns = 4; m_cnt = DR - 1;
      end
      else if (m_state == 4) begin
        if (m_cnt == 0) ns = 5; else m_cnt--;
      end
      else if (m_state == 2 && step_mode) ns = 3;
      else if (m_state == 3 && !step_mode) ns = 2;
      nrun = (ns == 2) || (ns == 4) || (ns == 3 && m_state == 3 && step_req && !m_run);
      m_state = ns;
      m_run   = nrun;
    end
  end

  function automatic longint cap4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(negedge clk) begin
    chk("state",        state,        m_state);
    chk("core_rst",     core_rst,     (m_state <= 1));
    chk("core_run",     core_run,     m_run);
    chk("fetch_en",     fetch_en,     (m_state == 2 || m_state == 3));
    chk("halted",       halted,       (m_state == 5));
    chk("cycle_count",  cycle_count,  m_cyc);
    chk("retire_count", retire_count, m_ret);
    chk("state4",       state4,       m_state);
    chk("core_run4",    core_run4,    m_run);
    chk("cycle_count4", cycle_count4, cap4(m_cyc));
    chk("retire_count4",retire_count4,cap4(m_ret));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_valid = 0; load_done = 0; step_req = 0; halt_req = 0;
    retire_valid = 0; retire_ebreak = 0;
  endtask

  task automatic wait_state(input int s, input string name);
    int n;
    n = 0;
    while (state != 3'(s) && n < 50) begin tick(); n++; end
    if (n >= 50) chk(name, state, s);
  endtask

  int n, rst_cycles, rv, runs;
  logic [31:0] frozen;

  initial begin
    rst = 1; step_mode = 0;
    clear_inputs();
    repeat (3) tick();
    chk("reset_state", state, 0);
    chk("reset_core_rst", core_rst, 1);
    chk("reset_core_run", core_run, 0);
    chk("reset_fetch_en", fetch_en, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cycle_count", cycle_count, 0);
    rst = 0;
    tick();

    // Load three words, then release.
    repeat (3) begin load_valid = 1; tick(); load_valid = 0; tick(); end
    load_done = 1; tick(); load_done = 0;
    n = 1; rst_cycles = 0;
    while (!core_run && n < 50) begin
      if (core_rst) rst_cycles++;
      tick(); n++;
    end
    chk("release_latency", n, FL + 1);
    chk("flush_rst_cycles", rst_cycles, FL);
    chk("run_state", state, 2);

    // ebreak in the 20th advancing cycle.
    rv = 0;
    for (int k = 1; k <= 20; k++) begin
      retire_valid  = (k % 3 == 0) || (k == 20);
      retire_ebreak = (k == 20);
      if (retire_valid) rv++;
      tick();
    end
    clear_inputs();
    chk("ebreak_halted", halted, 1);
    chk("ebreak_cycle_count", cycle_count, 20);
    chk("ebreak_retire_count", retire_count, rv);

    // Re-run the same image, then graceful halt.
    load_done = 1; tick(); load_done = 0;
    wait_state(2, "rerun_wait");
    repeat (3) tick();
    halt_req = 1; tick(); halt_req = 0;
    n = 0;
    while (core_run && !fetch_en && n < 20) begin n++; tick(); end
    chk("drain_cycles", n, DR);
    chk("drain_halted", halted, 1);

    // Single-step with a back-to-back pair (second of the pair is dropped).
    step_mode = 1;
    load_done = 1; tick(); load_done = 0;
    wait_state(3, "step_wait");
    runs = 0;
    step_req = 1; tick(); runs += int'(core_run);
    tick(); runs += int'(core_run);
    step_req = 0; tick(); runs += int'(core_run);
    tick(); runs += int'(core_run);
    step_req = 1; tick(); runs += int'(core_run);
    step_req = 0; tick(); runs += int'(core_run);
    tick(); runs += int'(core_run);
    step_req = 1; tick(); runs += int'(core_run);
    step_req = 0;
    repeat (3) begin tick(); runs += int'(core_run); end
    chk("step_runs", runs, 3);
    chk("step_cycle_count", cycle_count, 3);

    // Abort mid-run with a new program word.
    step_mode = 0;
    tick();
    chk("step_to_run", state, 2);
    repeat (5) tick();
    load_valid = 1; tick(); load_valid = 0;
    chk("abort_state", state, 0);
    chk("abort_core_rst", core_rst, 1);
    frozen = cycle_count;
    repeat (5) tick();
    chk("abort_frozen", cycle_count, frozen);
    load_done = 1; tick(); load_done = 0;
    chk("reload_clear_cycle", cycle_count, 0);
    chk("reload_clear_retire", retire_count, 0);

    // Saturation of the 4-bit instance.
    wait_state(2, "sat_wait");
    repeat (20) tick();
    chk("sat_cycle_count32", cycle_count, 20);
    chk("sat_cycle_count4", cycle_count4, 15);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(799) == 0);
      load_valid    = ($urandom_range(199) == 0);
      load_done     = !load_valid && ($urandom_range(39) == 0);
      if ($urandom_range(49) == 0) step_mode = ~step_mode;
      step_req      = ($urandom_range(3) == 0);
      halt_req      = ($urandom_range(59) == 0);
      retire_valid  = ($urandom_range(1) == 0);
      retire_ebreak = ($urandom_range(14) == 0);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
